wb_dest_pipe: RTL and testbench

Parametrised writeback-destination tracker for the CPU pipeline.
- Selects the destination register address from NUM_SRC decoded instruction fields.
- Carries it with a valid bit through DEPTH pipeline stages.
- Presents the final-stage address to the register-file write port.
- Compares in-flight destinations against two read addresses, giving hazard and forward-select indications.
- An invalid slot replaces the old high-impedance NOP output.

---
 rtl/wb_dest_pipe_pkg.sv | 26 ++
 rtl/wb_dest_match.sv | 43 ++++
 rtl/wb_dest_pipe.sv | 114 +++++++++++
 tb/tb_wb_dest_pipe.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/wb_dest_pipe_pkg.sv
// Shared definitions for the writeback-destination tracker: default address width,
// writeback source-select codes and a valid-count helper.
package wb_dest_pipe_pkg;

    localparam int unsigned RegAddrWDef = 4;

    // Source-select codes for a three-field decoder; any code >= NUM_SRC is a NOP.
    typedef enum logic [1:0] {
        WbOpRx  = 2'd0,
        WbOpRy  = 2'd1,
        WbOpRz  = 2'd2,
        WbOpNop = 2'd3
    } wb_addr_op_e;

    // Each stage entry is {valid, addr}; the pipe keeps the two fields in parallel
    // packed vectors, stage 1 in the lowest slice.
    function automatic int unsigned popcount(logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/wb_dest_match.sv
// Per-read-port hazard detect: flags any valid in-flight destination equal to the read
// address and returns the youngest matching stage. WB_ZERO_SKIP_EN makes register 0 never match.
module wb_dest_match
    import wb_dest_pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = RegAddrWDef,
    parameter int unsigned DEPTH      = 3,
    localparam int unsigned FWD_W     = $clog2(DEPTH) + 1
) (
    input  logic [DEPTH*REG_ADDR_W-1:0] stage_addr_i,
    input  logic [DEPTH-1:0]            stage_valid_i,
    input  logic [REG_ADDR_W-1:0]       rd_addr_i,
    output logic                        hazard_o,
    output logic [FWD_W-1:0]            fwd_o
);

    logic [DEPTH-1:0] match;

    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match[i] = stage_valid_i[i] &&
                       (stage_addr_i[i*REG_ADDR_W +: REG_ADDR_W] == rd_addr_i);
        end
`ifdef WB_ZERO_SKIP_EN
        if (rd_addr_i == '0) begin
            match = '0;
        end
`endif
    end

    // Scan oldest to youngest so the lowest (youngest) matching index is the one kept.
    always_comb begin
        hazard_o = |match;
        fwd_o    = '1;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (match[i]) begin
                fwd_o = FWD_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_dest_pipe.sv
// Writeback-destination tracker: selects a destination field, carries {valid, addr} through
// DEPTH stages and reports hazards per read port. Optional macro: WB_ZERO_SKIP_EN.
module wb_dest_pipe
    import wb_dest_pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = RegAddrWDef,
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned OP_W       = 2,
    parameter int unsigned DEPTH      = 3,
    localparam int unsigned FWD_W     = $clog2(DEPTH) + 1,
    localparam int unsigned INFL_W    = $clog2(DEPTH + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [OP_W-1:0]               wb_addr_op_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr_i,
    input  logic                          stall_i,
    input  logic                          flush_i,
    input  logic [REG_ADDR_W-1:0]         rd_addr_a_i,
    input  logic [REG_ADDR_W-1:0]         rd_addr_b_i,
    output logic [DEPTH*REG_ADDR_W-1:0]   stage_addr_o,
    output logic [DEPTH-1:0]              stage_valid_o,
    output logic [REG_ADDR_W-1:0]         wb_addr_o,
    output logic                          wb_en_o,
    output logic                          hazard_a_o,
    output logic                          hazard_b_o,
    output logic [FWD_W-1:0]              fwd_a_o,
    output logic [FWD_W-1:0]              fwd_b_o,
    output logic [INFL_W-1:0]             inflight_o
);

    logic                        sel_valid;
    logic [REG_ADDR_W-1:0]       sel_addr;
    logic [DEPTH*REG_ADDR_W-1:0] stage_addr_d, stage_addr_q;
    logic [DEPTH-1:0]            stage_valid_d, stage_valid_q;
    logic [INFL_W-1:0]           inflight_d, inflight_q;

    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (wb_addr_op_i == OP_W'(i)) begin
                sel_valid = 1'b1;
                sel_addr  = src_addr_i[i*REG_ADDR_W +: REG_ADDR_W];
            end
        end
`ifdef WB_ZERO_SKIP_EN
        if (sel_addr == '0) begin
            sel_valid = 1'b0;
        end
`endif
    end

    // A stalled flush kills stage 1 in place; its stale address is left as-is.
    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_addr_d  = stage_addr_q;
        if (stall_i) begin
            if (flush_i) begin
                stage_valid_d[0] = 1'b0;
            end
        end else begin
            stage_valid_d[0]              = sel_valid & ~flush_i;
            stage_addr_d[REG_ADDR_W-1:0]  = sel_addr;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage_valid_d[k] = stage_valid_q[k-1];
                stage_addr_d[k*REG_ADDR_W +: REG_ADDR_W] =
                    stage_addr_q[(k-1)*REG_ADDR_W +: REG_ADDR_W];
            end
        end
        inflight_d = INFL_W'(popcount(32'(stage_valid_d)));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stage_valid_q <= '0;
            stage_addr_q  <= '0;
            inflight_q    <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_addr_q  <= stage_addr_d;
            inflight_q    <= inflight_d;
        end
    end

    assign stage_addr_o  = stage_addr_q;
    assign stage_valid_o = stage_valid_q;
    assign wb_addr_o     = stage_addr_q[(DEPTH-1)*REG_ADDR_W +: REG_ADDR_W];
    assign wb_en_o       = stage_valid_q[DEPTH-1];
    assign inflight_o    = inflight_q;

    wb_dest_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .DEPTH      (DEPTH)
    ) u_match_a (
        .stage_addr_i  (stage_addr_q),
        .stage_valid_i (stage_valid_q),
        .rd_addr_i     (rd_addr_a_i),
        .hazard_o      (hazard_a_o),
        .fwd_o         (fwd_a_o)
    );

    wb_dest_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .DEPTH      (DEPTH)
    ) u_match_b (
        .stage_addr_i  (stage_addr_q),
        .stage_valid_i (stage_valid_q),
        .rd_addr_i     (rd_addr_b_i),
        .hazard_o      (hazard_b_o),
        .fwd_o         (fwd_b_o)
    );

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Directed bench for wb_dest_pipe (REG_ADDR_W=4, NUM_SRC=3, DEPTH=3); honours WB_ZERO_SKIP_EN.
module tb_wb_dest_pipe;
    import wb_dest_pipe_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  op;
    logic [11:0] src;
    logic        stall;
    logic        flush;
    logic [3:0]  rd_a;
    logic [3:0]  rd_b;
    logic [11:0] stage_addr;
    logic [2:0]  stage_valid;
    logic [3:0]  wb_addr;
    logic        wb_en;
    logic        hazard_a;
    logic        hazard_b;
    logic [2:0]  fwd_a;
    logic [2:0]  fwd_b;
    logic [1:0]  inflight;

    int n_asserts = 0;
    int n_fail    = 0;

    wb_dest_pipe #(
        .REG_ADDR_W (4),
        .NUM_SRC    (3),
        .OP_W       (2),
        .DEPTH      (3)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .wb_addr_op_i  (op),
        .src_addr_i    (src),
        .stall_i       (stall),
        .flush_i       (flush),
        .rd_addr_a_i   (rd_a),
        .rd_addr_b_i   (rd_b),
        .stage_addr_o  (stage_addr),
        .stage_valid_o (stage_valid),
        .wb_addr_o     (wb_addr),
        .wb_en_o       (wb_en),
        .hazard_a_o    (hazard_a),
        .hazard_b_o    (hazard_b),
        .fwd_a_o       (fwd_a),
        .fwd_b_o       (fwd_b),
        .inflight_o    (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. reset
        rst_n = 1'b0; op = WbOpRx; src = 12'h753; stall = 1'b0; flush = 1'b0;
        rd_a = 4'h0; rd_b = 4'h0;
        tick();
        tick();
        chk("rst_valid", 16'(stage_valid), 16'h0);
        chk("rst_addr", 16'(stage_addr), 16'h0);
        chk("rst_inflight", 16'(inflight), 16'h0);
        chk("rst_wb_en", 16'(wb_en), 16'h0);
        chk("rst_fwd_a", 16'(fwd_a), 16'h7);
        chk("rst_hazard_a", 16'(hazard_a), 16'h0);

        // 2. pipeline flow of ry=5
        rst_n = 1'b1; op = WbOpRy;
        tick();
        chk("flow1_valid", 16'(stage_valid), 16'h1);
        chk("flow1_addr", 16'(stage_addr), 16'h005);
        chk("flow1_inflight", 16'(inflight), 16'h1);
        op = WbOpNop; rd_a = 4'h5;
        tick();
        chk("flow2_valid", 16'(stage_valid), 16'h2);
        chk("flow2_addr", 16'(stage_addr), 16'h050);
        chk("flow2_hazard_a", 16'(hazard_a), 16'h1);
        chk("flow2_fwd_a", 16'(fwd_a), 16'h1);
        tick();
        chk("flow3_valid", 16'(stage_valid), 16'h4);
        chk("flow3_wb_addr", 16'(wb_addr), 16'h5);
        chk("flow3_wb_en", 16'(wb_en), 16'h1);
        tick();
        chk("flow4_valid", 16'(stage_valid), 16'h0);
        chk("flow4_wb_addr", 16'(wb_addr), 16'h0);
        chk("flow4_wb_en", 16'(wb_en), 16'h0);
        chk("flow4_inflight", 16'(inflight), 16'h0);

        // 3. stall and flush
        op = WbOpRz; rd_a = 4'h0;
        tick();
        chk("ins_rz_addr", 16'(stage_addr), 16'h007);
        stall = 1'b1; op = WbOpNop;
        tick();
        tick();
        chk("stall_valid", 16'(stage_valid), 16'h1);
        chk("stall_addr", 16'(stage_addr), 16'h007);
        chk("stall_inflight", 16'(inflight), 16'h1);
        stall = 1'b0; op = WbOpRx;
        tick();
        op = WbOpRy;
        tick();
        chk("fill_valid", 16'(stage_valid), 16'h7);
        chk("fill_addr", 16'(stage_addr), 16'h735);
        chk("fill_inflight", 16'(inflight), 16'h3);
        stall = 1'b1; flush = 1'b1; op = WbOpRz;
        tick();
        chk("sflush_valid", 16'(stage_valid), 16'h6);
        chk("sflush_addr", 16'(stage_addr), 16'h735);
        chk("sflush_inflight", 16'(inflight), 16'h2);
        stall = 1'b0; flush = 1'b1; op = WbOpRx;
        tick();
        chk("flush_valid", 16'(stage_valid), 16'h4);
        chk("flush_addr", 16'(stage_addr), 16'h353);
        chk("flush_wb_addr", 16'(wb_addr), 16'h3);
        chk("flush_inflight", 16'(inflight), 16'h1);

        // 4. forwarding priority: stages 1 and 3 hold 2
        flush = 1'b0; src = 12'h752; op = WbOpRx;
        tick();
        op = WbOpRy;
        tick();
        op = WbOpRx;
        tick();
        rd_a = 4'h2; rd_b = 4'h9;
        #1;
        chk("fwd_addr", 16'(stage_addr), 16'h252);
        chk("fwd_hazard_a", 16'(hazard_a), 16'h1);
        chk("fwd_a_young", 16'(fwd_a), 16'h0);
        chk("fwd_hazard_b_none", 16'(hazard_b), 16'h0);
        chk("fwd_b_none", 16'(fwd_b), 16'h7);
        rd_b = 4'h5;
        #1;
        chk("fwd_b_mid", 16'(fwd_b), 16'h1);
        chk("fwd_hazard_b", 16'(hazard_b), 16'h1);
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("fwd_a_old", 16'(fwd_a), 16'h2);
        chk("fwd_hazard_a_old", 16'(hazard_a), 16'h1);
        chk("fwd_inflight", 16'(inflight), 16'h2);

        // 5. invalid op inserts a bubble
        stall = 1'b0; flush = 1'b0; op = WbOpNop; rd_a = 4'h0; rd_b = 4'h9;
        tick();
        chk("nop_valid", 16'(stage_valid), 16'h4);
        chk("nop_addr", 16'(stage_addr), 16'h520);
        src = 12'h750; op = WbOpRx;
        tick();
        chk("zero_addr", 16'(stage_addr), 16'h200);
`ifdef WB_ZERO_SKIP_EN
        chk("zero_valid", 16'(stage_valid), 16'h0);
        chk("zero_hazard_a", 16'(hazard_a), 16'h0);
        chk("zero_fwd_a", 16'(fwd_a), 16'h7);
`else
        chk("zero_valid", 16'(stage_valid), 16'h1);
        chk("zero_hazard_a", 16'(hazard_a), 16'h1);
        chk("zero_fwd_a", 16'(fwd_a), 16'h0);
`endif

        // 6. mid-operation reset overrides stall
        src = 12'h753; op = WbOpRx;
        tick();
        op = WbOpRy;
        tick();
        op = WbOpRz;
        tick();
        chk("pre_rst_valid", 16'(stage_valid), 16'h7);
        chk("pre_rst_inflight", 16'(inflight), 16'h3);
        rst_n = 1'b0; stall = 1'b1;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", 16'(stage_valid), 16'h0);
        chk("mid_rst_addr", 16'(stage_addr), 16'h0);
        chk("mid_rst_inflight", 16'(inflight), 16'h0);
        chk("mid_rst_wb_en", 16'(wb_en), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
